// File: rtl/periph_bus.sv
// periph_bus: data-side slave with RAM, timer, LED/switch/7-seg and UART.
// Define PERIPH_UART_EN to build the UART transmitter (TXD/STAT).
module periph_bus #(
  parameter int RAM_WORDS = 256,
  parameter int BAUD_DIV  = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Mem_Addr,
  input  logic [31:0] MemWr_data,
  output logic [31:0] MemRd_data,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;

  logic [31:0] waddr;
  logic        unused_bits;
  logic        ram_sel;
  logic        sel_th;
  logic        sel_tl;
  logic        sel_tcon;
  logic        sel_led;
  logic        sel_sw;
  logic        sel_digi;
  logic        sel_txd;
  logic        sel_stat;
  logic [AW-1:0] ram_idx;

  assign waddr       = {Mem_Addr[31:2], 2'b00};
  assign unused_bits = ^Mem_Addr[1:0];
  assign ram_idx     = Mem_Addr[AW+1:2];
  assign ram_sel     = (Mem_Addr[31:AW+2] == '0);
  assign sel_th      = (waddr == A_TH);
  assign sel_tl      = (waddr == A_TL);
  assign sel_tcon    = (waddr == A_TCON);
  assign sel_led     = (waddr == A_LED);
  assign sel_sw      = (waddr == A_SW);
  assign sel_digi    = (waddr == A_DIGI);

  // ---------------- data RAM (never reset)
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWr && ram_sel)
      ram[ram_idx] <= MemWr_data;
  end

  // ---------------- timer and board registers
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic        wrap;

  assign wrap   = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign irqout = tcon[1] & tcon[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      digi <= '0;
    end else begin
      if (MemWr && sel_th)
        th <= MemWr_data;
      // CPU writes override counting and overflow
      if (MemWr && sel_tl)
        tl <= MemWr_data;
      else if (wrap)
        tl <= th;
      else if (tcon[0])
        tl <= tl + 32'd1;
      if (MemWr && sel_tcon)
        tcon <= MemWr_data[2:0];
      else if (wrap && tcon[1])
        tcon[2] <= 1'b1;
      if (MemWr && sel_led)
        led <= MemWr_data[7:0];
      if (MemWr && sel_digi)
        digi <= MemWr_data[11:0];
    end
  end

`ifdef PERIPH_UART_EN
  // ---------------- UART transmitter
  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } ustate_t;

  ustate_t       st;
  ustate_t       st_n;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic [7:0]    txd;
  logic [7:0]    txd_n;
  logic          busy;
  logic          div_last;

  assign sel_txd  = (waddr == 32'h4000_0018);
  assign sel_stat = (waddr == 32'h4000_0020);
  assign busy     = (st != U_IDLE);
  assign div_last = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= U_IDLE;
      div     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      txd     <= '0;
    end else begin
      st      <= st_n;
      div     <= div_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      txd     <= txd_n;
    end
  end

  always_comb begin
    st_n  = st;
    div_n = div;
    bit_n = bit_idx;
    sh_n  = sh;
    txd_n = txd;
    unique case (st)
      U_IDLE: begin
        if (MemWr && sel_txd) begin
          txd_n = MemWr_data[7:0];
          sh_n  = MemWr_data[7:0];
          div_n = '0;
          bit_n = '0;
          st_n  = U_START;
        end
      end
      U_START: begin
        if (div_last) begin
          div_n = '0;
          st_n  = U_DATA;
        end else begin
          div_n = div + 1'b1;
        end
      end
      U_DATA: begin
        if (div_last) begin
          div_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n = '0;
            st_n  = U_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      U_STOP: begin
        if (div_last) begin
          div_n = '0;
          st_n  = U_IDLE;
        end else begin
          div_n = div + 1'b1;
        end
      end
      default: st_n = U_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (st)
      U_START: uart_tx = 1'b0;
      U_DATA:  uart_tx = sh[0];
      default: uart_tx = 1'b1;
    endcase
  end
`else
  assign sel_txd  = 1'b0;
  assign sel_stat = 1'b0;
  assign uart_tx  = 1'b1;
`endif

  // ---------------- read mux
  always_comb begin
    MemRd_data = '0;
    if (MemRd) begin
      unique case (1'b1)
        ram_sel:  MemRd_data = ram[ram_idx];
        sel_th:   MemRd_data = th;
        sel_tl:   MemRd_data = tl;
        sel_tcon: MemRd_data = {29'd0, tcon};
        sel_led:  MemRd_data = {24'd0, led};
        sel_sw:   MemRd_data = {24'd0, switch};
        sel_digi: MemRd_data = {20'd0, digi};
`ifdef PERIPH_UART_EN
        sel_txd:  MemRd_data = {24'd0, txd};
        sel_stat: MemRd_data = {31'd0, busy};
`endif
        default:  MemRd_data = '0;
      endcase
    end
  end

endmodule
